prog_counter: RTL and testbench
===============================

# prog_counter

Program-counter and branch-sequencing block for the three-program core. It starts one of three programs on request, increments the PC each cycle and redirects it on taken branches. Branch targets come from the branch-target LUT: this block drives the LUT pointer, formed as the selected program's LUT base plus the instruction's 4-bit target index, and consumes the absolute address the LUT returns combinationally. It also reports completion to the test harness.

## Interface
Parameters:
- PC_W, 10, PC / absolute-address width
- PTR_W, 5, LUT pointer width
- START1 / START2 / START3, 0 / 0 / 0, start PC of programs 1/2/3
- BASE1 / BASE2 / BASE3, 0 / 7 / 15, LUT base index of programs 1/2/3
- PC_LIMIT, 1023, highest legal PC (used only with PC_LIMIT_EN)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- Start  in  1  start request, sampled in IDLE/DONE only
- ProgSel  in  2  program to start: 1, 2 or 3; 0 is invalid
- Halt  in  1  current instruction is a halt (decoder)
- BranchEn  in  1  current instruction is a conditional branch
- BranchCond  in  1  branch condition flag
- TargetIdx  in  4  branch target index from the instruction
- AbsAddress  in  PC_W  target returned by the LUT
- LutPointer  out  PTR_W  pointer to the LUT (combinational)
- ProgCtr  out  PC_W  current PC (registered)
- Running  out  1  1 in RUN
- Done  out  1  1 in DONE
- Fault  out  1  PC limit violation, sticky until Start or reset

## Operation
- States: IDLE, RUN, DONE; 2-bit ActiveProg register (0 = none).
- IDLE:
  - Start=1 and ProgSel∈{1,2,3}: latch ActiveProg, load ProgCtr←STARTn, go to RUN.
  - Start with ProgSel=0: ignored; stay in IDLE.
- RUN, per cycle, in priority order:
  - Halt=1: go to DONE; ProgCtr holds.
  - BranchEn & BranchCond: ProgCtr←AbsAddress.
  - Otherwise: ProgCtr←ProgCtr+1, mod 2^PC_W (1023 wraps to 0).
  - Start is ignored in RUN.
- DONE:
  - Done=1; ProgCtr holds.
  - Start with a valid ProgSel: behaves as from IDLE. Done clears and Fault clears on the same edge.
  - Start with ProgSel=0: ignored.
- LutPointer = BASE[ActiveProg] + TargetIdx, truncated to PTR_W.
  - Driven in RUN only; 0 in IDLE/DONE.
  - Valid regardless of BranchEn, so the LUT output is always settled.

## Timing
- Reset=0 at an edge: state←IDLE; ProgCtr=0, ActiveProg=0, Running=0, Done=0, Fault=0. This applies mid-RUN too; any pending branch or halt is discarded.
- Start→RUN latency: 1 edge. ProgCtr=STARTn and Running=1 are visible the cycle after Start is sampled.
- Branch: the target appears on ProgCtr 1 edge after the branch cycle. There is no delay slot.
- Halt: Done=1 and Running=0 one edge after Halt is sampled.
- Halt and BranchEn&BranchCond in the same cycle: the halt wins and the PC does not change.
- BranchEn=1, BranchCond=0: normal increment.
- LutPointer → AbsAddress is combinational within the same cycle.

## Configuration
- PC_LIMIT_EN defined, in RUN:
  - Any next-PC (increment or branch target) greater than PC_LIMIT sets Fault=1 and moves to DONE instead of updating ProgCtr.
  - Halt still takes priority.
  - Increment wrap is replaced by this check.
- PC_LIMIT_EN undefined:
  - Fault is tied to 0.
  - The PC wraps mod 2^PC_W and no limit is checked.

## Test plan
- Reset, then Start=1, ProgSel=2, START2=40 -> next cycle ProgCtr=40, Running=1. Five idle cycles later ProgCtr=45.
- Program 3 running, TargetIdx=4, BranchEn=1, BranchCond=1, LUT returns 200 -> LutPointer=19 in the same cycle; ProgCtr=200 the next cycle. Repeat with BranchCond=0 -> ProgCtr increments.
- Halt=1 with BranchEn=BranchCond=1 -> Done=1, Running=0, ProgCtr unchanged. Then Start, ProgSel=1 -> Done=0, ProgCtr=START1.
- Start with ProgSel=0 in IDLE -> state stays IDLE, ProgCtr=0, LutPointer=0. Start while in RUN -> no effect.
- Reset=0 mid-RUN at ProgCtr=77 -> next cycle ProgCtr=0, Running=0, Done=0, Fault=0.
- ProgCtr=1023 with no branch:
  - Without PC_LIMIT_EN: next ProgCtr=0.
  - With PC_LIMIT_EN and PC_LIMIT=100, at ProgCtr=100: Fault=1, Done=1, ProgCtr stays 100.

Source files
------------

// File: rtl/prog_counter.sv
// prog_counter: program counter and branch sequencer for the three-program core.
// Starts program 1, 2 or 3 on request. While running, the PC increments every
// cycle, jumps to the LUT-supplied address on taken branches, and stops on halt.
// Optional feature macro: PC_LIMIT_EN. When it is defined, a next PC above
// PC_LIMIT raises a sticky Fault and stops the program. When it is undefined,
// the PC wraps modulo 2^PC_W and Fault stays 0.
module prog_counter #(
  parameter int PC_W     = 10,
  parameter int PTR_W    = 5,
  parameter int START1   = 0,
  parameter int START2   = 0,
  parameter int START3   = 0,
  parameter int BASE1    = 0,
  parameter int BASE2    = 7,
  parameter int BASE3    = 15,
  parameter int PC_LIMIT = 1023
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             BranchCond,
  input  logic [3:0]       TargetIdx,
  input  logic [PC_W-1:0]  AbsAddress,
  output logic [PTR_W-1:0] LutPointer,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             Fault
);

`ifdef PC_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  // One extra bit holds the increment carry, so the limit check can see 1024.
  localparam logic [PC_W:0] LIMIT_EXT = (PC_W+1)'(PC_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       active_q, active_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             fault_q, fault_d;

  logic             start_ok;
  logic             taken;
  logic [PC_W:0]    next_ext;
  logic             limit_hit;
  logic [PC_W-1:0]  start_pc;
  logic [PTR_W-1:0] base_ptr;

  assign start_ok  = Start && (ProgSel != 2'd0);
  assign taken     = BranchEn && BranchCond;
  assign next_ext  = taken ? {1'b0, AbsAddress} : ({1'b0, pc_q} + (PC_W+1)'(1));
  assign limit_hit = LIMIT_ON && (next_ext > LIMIT_EXT);

  // Select the start PC of the requested program and the LUT base of the active one.
  always_comb begin
    start_pc = '0;
    base_ptr = '0;
    unique case (ProgSel)
      2'd1:    start_pc = PC_W'(START1);
      2'd2:    start_pc = PC_W'(START2);
      2'd3:    start_pc = PC_W'(START3);
      default: start_pc = '0;
    endcase
    unique case (active_q)
      2'd1:    base_ptr = PTR_W'(BASE1);
      2'd2:    base_ptr = PTR_W'(BASE2);
      2'd3:    base_ptr = PTR_W'(BASE3);
      default: base_ptr = '0;
    endcase
  end

  // Next-state logic: start, halt, taken branch, increment and limit fault.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pc_d     = pc_q;
    fault_d  = fault_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d  = ST_RUN;
          active_d = ProgSel;
          pc_d     = start_pc;
          fault_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_DONE;
        end else if (limit_hit) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
        end else begin
          pc_d = next_ext[PC_W-1:0];
        end
      end
      default: begin
        state_d  = ST_IDLE;
        active_d = 2'd0;
        pc_d     = '0;
        fault_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      active_q <= 2'd0;
      pc_q     <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pc_q     <= pc_d;
      fault_q  <= fault_d;
    end
  end

  // The LUT pointer is driven while running, even without a branch, so the LUT output is always settled.
  always_comb begin
    LutPointer = '0;
    if (state_q == ST_RUN) begin
      LutPointer = base_ptr + PTR_W'(TargetIdx);
    end
  end

  assign ProgCtr = pc_q;
  assign Running = (state_q == ST_RUN);
  assign Done    = (state_q == ST_DONE);
  assign Fault   = fault_q;

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed scenarios plus randomized cycles for prog_counter,
// checked against a behavioural model of the sequencing rules.
// Honours PC_LIMIT_EN: when it is defined, the DUT is built with PC_LIMIT=100.
module tb_prog_counter;
  localparam int PC_W  = 10;
  localparam int PTR_W = 5;
  localparam int S1 = 5, S2 = 40, S3 = 300;
  localparam int B1 = 0, B2 = 7, B3 = 15;
`ifdef PC_LIMIT_EN
  localparam int LIM    = 100;
  localparam bit LIM_ON = 1'b1;
`else
  localparam int LIM    = 1023;
  localparam bit LIM_ON = 1'b0;
`endif

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [1:0]       ProgSel;
  logic             Halt;
  logic             BranchEn;
  logic             BranchCond;
  logic [3:0]       TargetIdx;
  logic [PC_W-1:0]  AbsAddress;
  logic [PTR_W-1:0] LutPointer;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic             Fault;

  logic [PC_W-1:0] lut [32];
  assign AbsAddress = lut[LutPointer];

  prog_counter #(
    .PC_W(PC_W), .PTR_W(PTR_W),
    .START1(S1), .START2(S2), .START3(S3),
    .BASE1(B1), .BASE2(B2), .BASE3(B3),
    .PC_LIMIT(LIM)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .Halt(Halt), .BranchEn(BranchEn), .BranchCond(BranchCond),
    .TargetIdx(TargetIdx), .AbsAddress(AbsAddress),
    .LutPointer(LutPointer), .ProgCtr(ProgCtr),
    .Running(Running), .Done(Done), .Fault(Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: 0 = idle, 1 = running, 2 = done.
  int m_st, m_pc, m_prog;
  bit m_fault;

  function automatic int start_of(input int p);
    return (p == 1) ? S1 : (p == 2) ? S2 : (p == 3) ? S3 : 0;
  endfunction

  function automatic int base_of(input int p);
    return (p == 1) ? B1 : (p == 2) ? B2 : (p == 3) ? B3 : 0;
  endfunction

  function automatic int exp_ptr();
    return (m_st == 1) ? ((base_of(m_prog) + int'(TargetIdx)) % 32) : 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_in(input bit rst_n, input bit st, input int sel, input bit hlt,
                        input bit ben, input bit bc, input int idx);
    Reset      = rst_n;
    Start      = st;
    ProgSel    = 2'(sel);
    Halt       = hlt;
    BranchEn   = ben;
    BranchCond = bc;
    TargetIdx  = 4'(idx);
  endtask

  // Check outputs mid-cycle, advance the model by this cycle's inputs, then cross the edge.
  task automatic cycle();
    int nxt;
    @(negedge Clk);
    check_val("pc",      32'(ProgCtr),    32'(m_pc));
    check_val("running", 32'(Running),    32'(m_st == 1));
    check_val("done",    32'(Done),       32'(m_st == 2));
    check_val("fault",   32'(Fault),      32'(m_fault));
    check_val("lutptr",  32'(LutPointer), 32'(exp_ptr()));
    $display("cyc %0d rst_n=%0b start=%0b sel=%0d halt=%0b br=%0b%0b idx=%0d | pc=%0d run=%0b done=%0b fault=%0b ptr=%0d",
             cyc, Reset, Start, ProgSel, Halt, BranchEn, BranchCond, TargetIdx,
             ProgCtr, Running, Done, Fault, LutPointer);
    if (!Reset) begin
      m_st = 0; m_pc = 0; m_prog = 0; m_fault = 1'b0;
    end else if (m_st == 1) begin
      if (Halt) begin
        m_st = 2;
      end else begin
        nxt = (BranchEn && BranchCond) ? int'(lut[exp_ptr()]) : m_pc + 1;
        if (LIM_ON && nxt > LIM) begin
          m_fault = 1'b1;
          m_st    = 2;
        end else begin
          m_pc = nxt % (1 << PC_W);
        end
      end
    end else if (Start && ProgSel != 0) begin
      m_st = 1; m_prog = int'(ProgSel); m_pc = start_of(m_prog); m_fault = 1'b0;
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = PC_W'($urandom_range(0, 1023));
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    m_st = 0; m_pc = 0; m_prog = 0; m_fault = 1'b0;

    // Start with ProgSel=0 is ignored in IDLE.
    set_in(1, 1, 0, 0, 0, 0, 5);
    cycle();
    check_val("sel0_pc", 32'(ProgCtr), 32'd0);
    check_val("sel0_ptr", 32'(LutPointer), 32'd0);

    // Start program 2, then five plain cycles (one with a stray Start).
    set_in(1, 1, 2, 0, 0, 0, 0);
    cycle();
    check_val("start2_pc", 32'(ProgCtr), 32'd40);
    check_val("start2_run", 32'(Running), 32'd1);
    for (int i = 0; i < 5; i++) begin
      set_in(1, (i == 2), 1, 0, 0, 0, 0);
      cycle();
    end
    check_val("incr5_pc", 32'(ProgCtr), 32'd45);

    // Program 3 branch through LUT entry 15+4=19.
    lut[19] = 10'd200;
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    set_in(1, 1, 3, 0, 0, 0, 0);
    cycle();
    set_in(1, 0, 0, 0, 1, 1, 4);
    #1;
    check_val("ptr19", 32'(LutPointer), 32'd19);
    cycle();
    check_val("branch_pc", 32'(ProgCtr), 32'd200);
    set_in(1, 0, 0, 0, 1, 0, 4);
    cycle();
    check_val("nottaken_pc", 32'(ProgCtr), 32'd201);

    // Halt beats a taken branch; restart with program 1 from DONE.
    set_in(1, 0, 0, 1, 1, 1, 4);
    cycle();
    check_val("halt_done", 32'(Done), 32'd1);
    check_val("halt_run", 32'(Running), 32'd0);
    check_val("halt_pc", 32'(ProgCtr), 32'd201);
    set_in(1, 1, 1, 0, 0, 0, 0);
    cycle();
    check_val("restart_done", 32'(Done), 32'd0);
    check_val("restart_pc", 32'(ProgCtr), 32'd5);

    // Reset mid-run at PC 77.
    lut[3] = 10'd77;
    set_in(1, 0, 0, 0, 1, 1, 3);
    cycle();
    check_val("pc77", 32'(ProgCtr), 32'd77);
    set_in(0, 0, 0, 1, 1, 1, 3);
    cycle();
    check_val("rst_pc", 32'(ProgCtr), 32'd0);
    check_val("rst_run", 32'(Running), 32'd0);
    check_val("rst_done", 32'(Done), 32'd0);
    check_val("rst_fault", 32'(Fault), 32'd0);

    // PC boundary: limit fault or wrap to 0.
    set_in(1, 1, 1, 0, 0, 0, 0);
    cycle();
`ifdef PC_LIMIT_EN
    lut[5] = 10'd100;
    set_in(1, 0, 0, 0, 1, 1, 5);
    cycle();
    check_val("lim_pc100", 32'(ProgCtr), 32'd100);
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle();
    check_val("lim_fault", 32'(Fault), 32'd1);
    check_val("lim_done", 32'(Done), 32'd1);
    check_val("lim_pc", 32'(ProgCtr), 32'd100);
`else
    lut[6] = 10'd1023;
    set_in(1, 0, 0, 0, 1, 1, 6);
    cycle();
    check_val("wrap_pc1023", 32'(ProgCtr), 32'd1023);
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle();
    check_val("wrap_pc0", 32'(ProgCtr), 32'd0);
    check_val("wrap_fault", 32'(Fault), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        lut[$urandom_range(0, 31)] = ($urandom_range(0, 1) == 1) ?
            PC_W'($urandom_range(0, 120)) : PC_W'($urandom_range(0, 1023));
      end
      set_in(($urandom_range(0, 49) != 0),
             ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 1) == 1),
             int'($urandom_range(0, 15)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
